// File: rtl/reg_writeback_queue_if.sv
// Bus bundle for the register write-back queue: request input, register-bank
// write port, bypass lookups and occupancy status.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          InValid;
    logic          InReady;
    logic [4:0]    InRegister;
    logic [31:0]   InData;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [31:0]   WriteData;
    logic          WriteReady;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic          Hit1;
    logic          Hit2;
    logic [31:0]   BypassData1;
    logic [31:0]   BypassData2;
    logic [CW-1:0] Count;
    logic          Empty;
    logic          Full;

    modport master (
        output InValid, InRegister, InData, WriteReady, ReadRegister1, ReadRegister2,
        input  InReady, RegWrite, WriteRegister, WriteData, Hit1, Hit2,
               BypassData1, BypassData2, Count, Empty, Full
    );

    modport slave (
        input  InValid, InRegister, InData, WriteReady, ReadRegister1, ReadRegister2,
        output InReady, RegWrite, WriteRegister, WriteData, Hit1, Hit2,
               BypassData1, BypassData2, Count, Empty, Full
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Circular FIFO of pending register write-backs that drains into the register
// bank and offers a youngest-match bypass lookup on two read ports.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]    entry_reg  [DEPTH];
    logic [31:0]   entry_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          accept;
    logic          push;
    logic          pop;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot early.
    assign bus.Full    = (count == CW'(DEPTH));
    assign bus.Empty   = (count == '0);
    assign bus.InReady = !bus.Full;
    assign bus.Count   = count;

    // Writes to $0 finish the handshake but never occupy an entry.
    assign accept = bus.InValid && bus.InReady;
    assign push   = accept && (bus.InRegister != 5'd0);
    assign pop    = !bus.Empty && bus.WriteReady;

    assign bus.RegWrite      = !bus.Empty;
    assign bus.WriteRegister = bus.Empty ? 5'd0  : entry_reg[head];
    assign bus.WriteData     = bus.Empty ? 32'd0 : entry_data[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i]  <= '0;
                entry_data[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entry_reg[tail]  <= bus.InRegister;
                entry_data[tail] <= bus.InData;
                tail             <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    logic [PW-1:0] idx;
    logic          hit1;
    logic          hit2;
    logic [31:0]   byp1;
    logic [31:0]   byp2;

    // Walk oldest to youngest so the last match seen is the one closest to tail.
    always_comb begin
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (bus.ReadRegister1 != 5'd0 && entry_reg[idx] == bus.ReadRegister1) begin
                    hit1 = 1'b1;
                    byp1 = entry_data[idx];
                end
                if (bus.ReadRegister2 != 5'd0 && entry_reg[idx] == bus.ReadRegister2) begin
                    hit2 = 1'b1;
                    byp2 = entry_data[idx];
                end
            end
        end
    end

    assign bus.Hit1        = hit1;
    assign bus.Hit2        = hit2;
    assign bus.BypassData1 = byp1;
    assign bus.BypassData2 = byp2;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: a scoreboard models accepted
// writes, checks drain order, status and bypass each cycle, plus directed scenarios.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [36:0] sb[$];

    reg_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one request cycle starting at posedge+1; the request is dropped right after the edge.
    task automatic applyStimulus(input logic v, input logic [4:0] r, input logic [31:0] d, input logic wr);
        bus.InValid    = v;
        bus.InRegister = r;
        bus.InData     = d;
        bus.WriteReady = wr;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    function automatic logic [32:0] modelBypass(input logic [4:0] rr);
        if (rr == 5'd0) return 33'd0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j][36:32] == rr) return {1'b1, sb[j][31:0]};
        end
        return 33'd0;
    endfunction

    // Compare DUT state against the model, then apply what the coming edge will do.
    always @(negedge clk) begin
        logic [32:0] b1;
        logic [32:0] b2;
        logic        accepted;
        if (!rst_n) begin
            sb.delete();
        end else begin
            checkOutput("count", 32'(bus.Count), 32'(sb.size()));
            checkOutput("in_ready", 32'(bus.InReady), 32'(sb.size() < DEPTH));
            checkOutput("empty", 32'(bus.Empty), 32'(sb.size() == 0));
            checkOutput("full", 32'(bus.Full), 32'(sb.size() == DEPTH));
            checkOutput("reg_write", 32'(bus.RegWrite), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                checkOutput("write_reg", 32'(bus.WriteRegister), 32'(sb[0][36:32]));
                checkOutput("write_data", bus.WriteData, sb[0][31:0]);
            end else begin
                checkOutput("write_reg_idle", 32'(bus.WriteRegister), 32'd0);
                checkOutput("write_data_idle", bus.WriteData, 32'd0);
            end
            b1 = modelBypass(bus.ReadRegister1);
            b2 = modelBypass(bus.ReadRegister2);
            checkOutput("hit1", 32'(bus.Hit1), 32'(b1[32]));
            checkOutput("bypass1", bus.BypassData1, b1[31:0]);
            checkOutput("hit2", 32'(bus.Hit2), 32'(b2[32]));
            checkOutput("bypass2", bus.BypassData2, b2[31:0]);
            accepted = bus.InValid && (sb.size() < DEPTH);
            if (sb.size() != 0 && bus.WriteReady) void'(sb.pop_front());
            if (accepted && bus.InRegister != 5'd0) sb.push_back({bus.InRegister, bus.InData});
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.InValid       = 1'b0;
        bus.InRegister    = '0;
        bus.InData        = '0;
        bus.WriteReady    = 1'b0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        #3;
        checkOutput("rst_count", 32'(bus.Count), 32'd0);
        checkOutput("rst_empty", 32'(bus.Empty), 32'd1);
        checkOutput("rst_in_ready", 32'(bus.InReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single write with latency one, then empty.
        applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b1);
        checkOutput("s1_reg_write", 32'(bus.RegWrite), 32'd1);
        checkOutput("s1_write_reg", 32'(bus.WriteRegister), 32'd5);
        checkOutput("s1_write_data", bus.WriteData, 32'hAA);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("s1_empty", 32'(bus.Empty), 32'd1);

        // Fill, refuse a fifth request, drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
        checkOutput("s2_full", 32'(bus.Full), 32'd1);
        checkOutput("s2_in_ready", 32'(bus.InReady), 32'd0);
        checkOutput("s2_count", 32'(bus.Count), 32'd4);
        applyStimulus(1'b1, 5'd9, 32'h999, 1'b0);
        checkOutput("s2_refused", 32'(bus.Count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("s2_drain_reg", 32'(bus.WriteRegister), 32'(i));
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        end
        checkOutput("s2_empty", 32'(bus.Empty), 32'd1);

        // Register zero is accepted but dropped.
        bus.InValid = 1'b1;
        bus.InRegister = 5'd0;
        #1;
        checkOutput("s3_in_ready", 32'(bus.InReady), 32'd1);
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        checkOutput("s3_count", 32'(bus.Count), 32'd0);
        checkOutput("s3_reg_write", 32'(bus.RegWrite), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

        // Youngest-match bypass.
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b0);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b0);
        bus.ReadRegister1 = 5'd7;
        bus.ReadRegister2 = 5'd0;
        #1;
        checkOutput("s4_hit1", 32'(bus.Hit1), 32'd1);
        checkOutput("s4_bypass1", bus.BypassData1, 32'h22);
        checkOutput("s4_hit2", 32'(bus.Hit2), 32'd0);
        checkOutput("s4_bypass2", bus.BypassData2, 32'd0);
        bus.InValid = 1'b1;
        bus.InRegister = 5'd7;
        bus.InData = 32'h33;
        #1;
        checkOutput("s4_no_inflight", bus.BypassData1, 32'h22);
        bus.InValid = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        bus.ReadRegister1 = 5'd0;

        // Push and pop together, then reset mid-stream.
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b0);
        applyStimulus(1'b1, 5'd11, 32'hB0, 1'b0);
        applyStimulus(1'b1, 5'd12, 32'hC0, 1'b1);
        checkOutput("s5_count", 32'(bus.Count), 32'd2);
        checkOutput("s5_head", 32'(bus.WriteRegister), 32'd11);
        bus.WriteReady = 1'b0;
        bus.ReadRegister1 = 5'd11;
        bus.ReadRegister2 = 5'd12;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_count", 32'(bus.Count), 32'd0);
        checkOutput("s5_rst_empty", 32'(bus.Empty), 32'd1);
        checkOutput("s5_rst_full", 32'(bus.Full), 32'd0);
        checkOutput("s5_rst_in_ready", 32'(bus.InReady), 32'd1);
        checkOutput("s5_rst_reg_write", 32'(bus.RegWrite), 32'd0);
        checkOutput("s5_rst_write_reg", 32'(bus.WriteRegister), 32'd0);
        checkOutput("s5_rst_write_data", bus.WriteData, 32'd0);
        checkOutput("s5_rst_hit1", 32'(bus.Hit1), 32'd0);
        checkOutput("s5_rst_hit2", 32'(bus.Hit2), 32'd0);
        checkOutput("s5_rst_bypass1", bus.BypassData1, 32'd0);
        checkOutput("s5_rst_bypass2", bus.BypassData2, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd13, 32'hD0, 1'b0);
        checkOutput("s5_first_push", 32'(bus.WriteRegister), 32'd13);
        checkOutput("s5_first_count", 32'(bus.Count), 32'd1);
        repeat (3) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("s5_no_old_write", 32'(bus.RegWrite), 32'd0);
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;

        // Random traffic with random back-pressure and bypass lookups.
        for (int i = 0; i < 20; i++) begin
            bus.ReadRegister1 = 5'($urandom_range(0, 31));
            bus.ReadRegister2 = 5'($urandom_range(0, 31));
            applyStimulus(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 5'd0, 32'd0, 1'($urandom_range(0, 1)));
        end
        repeat (DEPTH + 2) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("s6_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
